biu_resp_mem: RTL and testbench

BIU_RESP_MEM -- requirements
Module: biu_resp_mem

---
 rtl/biu_resp_mem.sv | 167 ++++++++++++++++
 tb/tb_biu_resp_mem.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/biu_resp_mem.sv
// -----------------------------------------------------------------------------
// biu_resp_mem
//   Bus-slave memory with a fixed response latency and an in-order request
//   queue. Each accepted request waits LATENCY cycles before completing. A
//   completion that is blocked behind an older request completes in the cycle
//   right after that older one. Writes update only the addressed byte lanes.
//   Reads return lane-positioned data with the unaddressed lanes forced to
//   zero. Bad addresses, misaligned accesses and reserved sizes complete with
//   err_o and leave memory unchanged.
//
// Ports
//   clk_i   in   1     clock, all state changes on the rising edge
//   rst_i   in   1     synchronous active-high reset (memory array kept)
//   req_i   in   1     access request, accepted when busy_o is low
//   adr_i   in   XLEN  byte address
//   d_i     in   XLEN  write data, right-justified, moved to lane adr_i[1:0]
//   we_i    in   1     1 = write, 0 = read
//   size_i  in   2     BYTE / HWORD / WORD (SIZE_RSVD is an error)
//   busy_o  out  1     queue holds QDEPTH requests, new requests dropped
//   ack_o   out  1     one-cycle completion strobe
//   q_o     out  XLEN  read data, non-zero only on a successful read ack
//   err_o   out  1     completion is an error, only together with ack_o
// -----------------------------------------------------------------------------
package biu_pkg;
  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HWORD     = 2'b01,
    WORD      = 2'b10,
    SIZE_RSVD = 2'b11
  } biu_size_t;
endpackage

module biu_resp_mem
  import biu_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] ADDRESS_BASE = '0,
  parameter int              DEPTH        = 1024,
  parameter int              LATENCY      = 2,
  parameter int              QDEPTH       = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [XLEN-1:0] adr_i,
  input  logic [XLEN-1:0] d_i,
  input  logic            we_i,
  input  biu_size_t       size_i,
  output logic            busy_o,
  output logic            ack_o,
  output logic [XLEN-1:0] q_o,
  output logic            err_o
);

  localparam int              NB       = XLEN / 8;
  localparam int              PW       = $clog2(QDEPTH);
  localparam int              AW       = $clog2(DEPTH);
  localparam logic [XLEN:0]   LIMIT    = (XLEN + 1)'(4 * DEPTH);
  localparam logic [3:0]      LAT_INIT = 4'(LATENCY - 1);
  localparam logic [PW:0]     FULL_CNT = (PW + 1)'(QDEPTH);

  typedef struct packed {
    logic [XLEN-1:0] adr;
    logic [XLEN-1:0] d;
    logic            we;
    biu_size_t       size;
  } entry_t;

  // Request queue: payload, per-entry remaining wait, and pointers.
  entry_t          r_q   [QDEPTH];
  logic [3:0]      r_cnt [QDEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW:0]     r_count;
  logic [XLEN-1:0] r_mem [DEPTH];

  logic            w_push;
  logic            w_head_ready;
  entry_t          w_head;
  logic [XLEN-1:0] w_off;
  logic            w_in_range;
  logic [AW-1:0]   w_idx;
  logic [1:0]      w_lane;
  logic [NB-1:0]   w_be;
  logic            w_align;
  logic            w_err;
  logic [XLEN-1:0] w_mask;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_rdata;

  assign busy_o       = (r_count == FULL_CNT);
  assign w_push       = req_i & ~busy_o;
  assign w_head       = r_q[r_rptr];
  // The head completes once its wait has run out; older entries always
  // finish first, so a younger entry whose wait expired early simply follows.
  assign w_head_ready = (r_count != '0) && (r_cnt[r_rptr] == 4'd0);
  // A completion that coincides with reset is discarded, never reported.
  assign ack_o        = w_head_ready & ~rst_i;

  // Address and size decode of the head entry.
  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    w_off      = w_head.adr - ADDRESS_BASE;
    w_in_range = (w_head.adr >= ADDRESS_BASE) && ({1'b0, w_off} < LIMIT);
    w_idx      = w_off[AW+1:2];
    w_lane     = w_head.adr[1:0];
    w_be       = '0;
    w_align    = 1'b0;
    case (w_head.size)
      BYTE:    begin w_be = NB'(4'b0001) << w_lane; w_align = 1'b1;              end
      HWORD:   begin w_be = NB'(4'b0011) << w_lane; w_align = ~w_lane[0];        end
      WORD:    begin w_be = NB'(4'b1111);           w_align = (w_lane == 2'b00); end
      default: ;
    endcase
    w_err  = ~w_in_range | ~w_align;
    w_mask = '0;
    for (int b = 0; b < NB; b++) w_mask[8*b +: 8] = {8{w_be[b]}};
    w_wdata = w_head.d << {w_lane, 3'b000};
    w_rdata = r_mem[w_idx] & w_mask;
  end

  assign q_o   = (ack_o && !w_err && !w_head.we) ? w_rdata : '0;
  assign err_o = ack_o & w_err;

  // Queue control. Every stored wait counts down to zero and stays there; a
  // push in the same edge overrides the countdown of the slot it fills.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < QDEPTH; i++) r_cnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (r_cnt[i] != 4'd0) r_cnt[i] <= r_cnt[i] - 4'd1;
      end
      if (w_push) begin
        r_cnt[r_wptr] <= LAT_INIT;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (ack_o) r_rptr <= r_rptr + 1'b1;
      case ({w_push, ack_o})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Queue payload needs no reset: it is only looked at while r_count says
  // the slot is occupied.
  always_ff @(posedge clk_i) begin
    if (w_push) r_q[r_wptr] <= '{adr: adr_i, d: d_i, we: we_i, size: size_i};
  end

  // NOTE: the memory array is deliberately left out of reset so contents
  // survive a mid-operation reset; only the write enable is qualified.
  always_ff @(posedge clk_i) begin
    if (ack_o && w_head.we && !w_err) begin
      r_mem[w_idx] <= (r_mem[w_idx] & ~w_mask) | (w_wdata & w_mask);
    end
  end

endmodule

// File: tb/tb_biu_resp_mem.sv
// -----------------------------------------------------------------------------
// tb_biu_resp_mem
//   Two instances of biu_resp_mem (LATENCY 2 and 4) share one stimulus stream.
//   Each instance keeps its own expected-request queue, filled at issue time,
//   and a byte-level memory model. A per-instance monitor compares every
//   cycle: ack presence and timing, error flag and read data.
// -----------------------------------------------------------------------------
module tb_biu_resp_mem;
  import biu_pkg::*;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          DEPTH  = 64;
  localparam int          QDEPTH = 4;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] d;
    logic        we;
    biu_size_t   size;
    int          acc;   // edge number at which the request is accepted
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] d   = '0;
  biu_size_t   size = BYTE;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  event        ev_issue;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar u = 0; u < 2; u++) begin : g_inst
    localparam int LAT = (u == 0) ? 2 : 4;

    logic        w_busy;
    logic        w_ack;
    logic        w_err;
    logic [31:0] w_q;

    req_t        exp_q[$];
    logic [31:0] mdl_mem [DEPTH];
    int          last_ack = -100;
    int          n_acks = 0;
    logic [31:0] last_q = '0;
    logic        last_err = 1'b0;

    biu_resp_mem #(
      .XLEN(32), .ADDRESS_BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT), .QDEPTH(QDEPTH)
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .req_i (req),
      .adr_i (adr),
      .d_i   (d),
      .we_i  (we),
      .size_i(size),
      .busy_o(w_busy),
      .ack_o (w_ack),
      .q_o   (w_q),
      .err_o (w_err)
    );

    // Reference behaviour of one completion, byte by byte.
    task automatic complete(input req_t e, output logic e_err, output logic [31:0] e_q);
      int     nbytes;
      int     off;
      int     idx;
      longint a;
      e_q = '0;
      a   = e.adr;
      case (e.size)
        BYTE:    nbytes = 1;
        HWORD:   nbytes = 2;
        WORD:    nbytes = 4;
        default: nbytes = 0;
      endcase
      if (nbytes == 0) e_err = 1'b1;
      else e_err = (a < BASE) || (a >= longint'(BASE) + 4 * DEPTH) || ((a % nbytes) != 0);
      if (!e_err) begin
        idx = int'((a - BASE) / 4);
        off = int'(a % 4);
        for (int b = 0; b < nbytes; b++) begin
          if (e.we) mdl_mem[idx][8*(off+b) +: 8] = e.d[8*b +: 8];
          else      e_q[8*(off+b) +: 8] = mdl_mem[idx][8*(off+b) +: 8];
        end
      end
    endtask

    // Issue side: the model decides acceptance from its own occupancy.
    always @(ev_issue) begin : p_issue
      logic full;
      if (!rst) begin
        full = (exp_q.size() == QDEPTH);
        check($sformatf("L%0d busy", LAT), 32'(w_busy), 32'(full));
        if (req && !full) exp_q.push_back('{adr: adr, d: d, we: we, size: size, acc: cyc + 1});
      end
    end

    // Monitor: an ack is due when the head has waited LAT-1 edges past its
    // acceptance and the previous ack was in an earlier cycle.
    always @(negedge clk) begin : p_mon
      logic        exp_ack;
      logic        e_err;
      logic [31:0] e_q;
      int          due;
      req_t        h;
      if (rst) begin
        check($sformatf("L%0d ack_in_reset", LAT), 32'(w_ack), 32'd0);
        exp_q.delete();
        last_ack = -100;
      end else begin
        exp_ack = 1'b0;
        if (exp_q.size() > 0) begin
          due = exp_q[0].acc + LAT - 1;
          if (last_ack + 1 > due) due = last_ack + 1;
          exp_ack = (due <= cyc);
        end
        check($sformatf("L%0d ack", LAT), 32'(w_ack), 32'(exp_ack));
        if (w_ack) n_acks++;
        if (exp_ack) begin
          if (w_ack) begin
            h = exp_q.pop_front();
            complete(h, e_err, e_q);
            check($sformatf("L%0d err @%h", LAT, h.adr), 32'(w_err), 32'(e_err));
            check($sformatf("L%0d q @%h", LAT, h.adr), w_q, e_q);
            last_ack = cyc;
            last_q   = w_q;
            last_err = w_err;
          end
        end else begin
          check($sformatf("L%0d idle_q", LAT), w_q, 32'd0);
          check($sformatf("L%0d idle_err", LAT), 32'(w_err), 32'd0);
        end
      end
    end
  end

  task automatic issue(input logic r, input logic w, input biu_size_t s,
                       input logic [31:0] a, input logic [31:0] dd);
    @(posedge clk);
    #1;
    req = r; we = w; size = s; adr = a; d = dd;
    -> ev_issue;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b0, BYTE, '0, '0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    -> ev_issue;
  endtask

  initial begin : p_main
    int a0, a1, pending, r;
    logic [31:0] ra;
    biu_size_t rs;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("L2 busy_after_reset", 32'(g_inst[0].w_busy), 32'd0);
    check("L4 busy_after_reset", 32'(g_inst[1].w_busy), 32'd0);
    check("L2 ack_after_reset",  32'(g_inst[0].w_ack),  32'd0);
    check("L4 ack_after_reset",  32'(g_inst[1].w_ack),  32'd0);

    // Give the first 16 words known contents in both memories.
    for (int i = 0; i < 16; i++) begin
      issue(1'b1, 1'b1, WORD, BASE + 32'(4 * i), $urandom);
      idle(1);
    end
    idle(6);

    // Word write then word read back, back to back.
    issue(1'b1, 1'b1, WORD, BASE + 32'd8, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, WORD, BASE + 32'd8, 32'h0);
    idle(8);
    check("L2 readback_deadbeef", g_inst[0].last_q, 32'hDEAD_BEEF);
    check("L4 readback_deadbeef", g_inst[1].last_q, 32'hDEAD_BEEF);
    check("L2 readback_err", 32'(g_inst[0].last_err), 32'd0);

    // Byte write merges into an existing word.
    issue(1'b1, 1'b1, WORD, BASE + 32'd4, 32'h1122_3344);
    issue(1'b1, 1'b1, BYTE, BASE + 32'd5, 32'h0000_00AA);
    issue(1'b1, 1'b0, WORD, BASE + 32'd4, 32'h0);
    idle(8);
    check("L2 byte_merge", g_inst[0].last_q, 32'h1122_AA44);
    check("L4 byte_merge", g_inst[1].last_q, 32'h1122_AA44);

    // Misaligned halfword and out-of-range word.
    issue(1'b1, 1'b0, HWORD, BASE + 32'd3, 32'h0);
    issue(1'b1, 1'b0, WORD, BASE + 32'(4 * DEPTH), 32'h0);
    idle(8);
    check("L2 oob_err", 32'(g_inst[0].last_err), 32'd1);
    check("L4 oob_err", 32'(g_inst[1].last_err), 32'd1);
    check("L4 oob_q",   g_inst[1].last_q, 32'd0);

    // Six back-to-back requests: the LATENCY 4 instance fills and drops one.
    a0 = g_inst[0].n_acks;
    a1 = g_inst[1].n_acks;
    for (int i = 0; i < 6; i++) issue(1'b1, 1'b0, WORD, BASE + 32'd4, 32'h0);
    idle(12);
    check("L2 burst_acks", 32'(g_inst[0].n_acks - a0), 32'd6);
    check("L4 burst_acks", 32'(g_inst[1].n_acks - a1), 32'd5);

    // Reset with writes pending: they vanish, memory keeps older values.
    a0 = g_inst[0].n_acks;
    a1 = g_inst[1].n_acks;
    issue(1'b1, 1'b1, WORD, BASE + 32'd0, 32'hAAAA_0000);
    issue(1'b1, 1'b1, WORD, BASE + 32'd4, 32'hBBBB_0004);
    issue(1'b1, 1'b1, WORD, BASE + 32'd12, 32'hCCCC_000C);
    reset_pulse();
    idle(8);
    check("L2 acks_across_reset", 32'(g_inst[0].n_acks - a0), 32'd1);
    check("L4 acks_across_reset", 32'(g_inst[1].n_acks - a1), 32'd0);
    check("L4 busy_post_reset", 32'(g_inst[1].w_busy), 32'd0);
    issue(1'b1, 1'b0, WORD, BASE + 32'd4, 32'h0);
    idle(8);
    check("L2 preserved_word", g_inst[0].last_q, 32'h1122_AA44);
    check("L4 preserved_word", g_inst[1].last_q, 32'h1122_AA44);
    issue(1'b1, 1'b0, WORD, BASE + 32'd0, 32'h0);
    issue(1'b1, 1'b0, WORD, BASE + 32'd12, 32'h0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) reset_pulse();
      r = int'($urandom_range(0, 15));
      rs = (r < 5) ? BYTE : (r < 10) ? HWORD : (r < 15) ? WORD : SIZE_RSVD;
      r = int'($urandom_range(0, 9));
      if (r == 0)      ra = BASE - 32'd4 + 32'($urandom_range(0, 3));
      else if (r == 1) ra = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
      else             ra = BASE + 32'($urandom_range(0, 63));
      issue(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rs, ra, $urandom);
    end

    // Drain with a bounded wait.
    pending = 1;
    for (int i = 0; i < 60 && pending > 0; i++) begin
      idle(1);
      pending = g_inst[0].exp_q.size() + g_inst[1].exp_q.size();
    end
    check("drain_pending", 32'(pending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
